score_scan_ctrl: RTL and testbench

Multiplexed score-display controller for the Snake board's 4-digit common-anode seven-segment display. It accepts a binary score through a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the four digits, presenting one 4-bit digit value at a time to the existing hex-to-seven-segment decoder and driving the matching active-low digit enable. Optional leading-zero blanking is applied per scan slot.

---
 rtl/score_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_score_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_scan_ctrl.sv
// rtl/score_scan_ctrl.sv - score-to-BCD converter and 4-digit multiplexed display scanner
// Double-dabble conversion into a shadow accumulator, committed to the display register only when complete.
module score_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score_in,
  input  logic        score_valid,
  output logic        score_ready,
  input  logic        blank_lz,
  output logic        busy,
  output logic [3:0]  digit_num,
  output logic [3:0]  digit_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [19:0] DIV_MAX    = 20'(SCAN_DIV - 1);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;
  localparam logic [3:0]  LAST_SHIFT = 4'd13;

  state_e      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [19:0] div_q, div_d;
  logic [1:0]  idx_q, idx_d;

  logic [15:0] bcd_adj;
  logic        div_wrap;
  logic [3:0]  zero_from;
  logic        blank_now;

  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (score_valid) state_d = CONV;
      CONV:    if (cnt_q == LAST_SHIFT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    score_ready = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE:    score_ready = 1'b1;
      CONV:    busy        = 1'b1;
      DONE:    busy        = 1'b1;
      default: score_ready = 1'b0;
    endcase
  end

  assign bcd_adj = dd_adjust(bcd_q);

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    case (state_q)
      IDLE: begin
        if (score_valid) begin
          bin_d = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;
          bcd_d = 16'd0;
          cnt_d = 4'd0;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      DONE:    disp_d = bcd_q;
      default: disp_d = disp_q;
    endcase
  end

  // Scan phase runs independently of the converter so display updates never disturb it.
  assign div_wrap = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_wrap ? 20'd0 : div_q + 20'd1;
    idx_d = div_wrap ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= 14'd0;
      bcd_q  <= 16'd0;
      cnt_q  <= 4'd0;
      disp_q <= 16'd0;
      div_q  <= 20'd0;
      idx_q  <= 2'd0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
    end
  end

  // zero_from[i]: nibbles i..3 of the display are all zero.
  always_comb begin
    zero_from[3] = (disp_q[15:12] == 4'd0);
    zero_from[2] = zero_from[3] && (disp_q[11:8] == 4'd0);
    zero_from[1] = zero_from[2] && (disp_q[7:4] == 4'd0);
    zero_from[0] = zero_from[1] && (disp_q[3:0] == 4'd0);
  end

  always_comb begin
    blank_now = blank_lz && (idx_q != 2'd0) && zero_from[idx_q];
    digit_num = disp_q[4*idx_q +: 4];
    digit_sel = blank_now ? 4'b1111 : ~(4'b0001 << idx_q);
  end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// tb/tb_score_scan_ctrl.sv - directed self-checking bench for score_scan_ctrl
// Two instances: slow scan (SCAN_DIV=4) and per-cycle scan (SCAN_DIV=1) share the same stimulus.
module tb_score_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [13:0] score_in;
  logic        score_valid;
  logic        blank_lz;
  logic        ready0, busy0, ready1, busy1;
  logic [3:0]  num0, sel0, num1, sel1;

  int n_vec;
  int n_err;
  int mcnt;

  score_scan_ctrl #(.SCAN_DIV(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score_in   (score_in),
    .score_valid(score_valid),
    .score_ready(ready0),
    .blank_lz   (blank_lz),
    .busy       (busy0),
    .digit_num  (num0),
    .digit_sel  (sel0)
  );

  score_scan_ctrl #(.SCAN_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .score_in   (score_in),
    .score_valid(score_valid),
    .score_ready(ready1),
    .blank_lz   (blank_lz),
    .busy       (busy1),
    .digit_num  (num1),
    .digit_sel  (sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // mcnt counts edges since reset release; it is the bench's model of the scan phase.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) mcnt++;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = v >> (4 * i);
    return s[3:0];
  endfunction

  function automatic logic [3:0] sel_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic scan(input string tag, input logic [15:0] bcd, input logic [3:0] lit, input int n);
    int         i;
    logic [3:0] en;
    for (int k = 0; k < n; k++) begin
      tick();
      i  = (mcnt / 4) % 4;
      en = lit >> i;
      chk({tag, "_num"}, 16'(num0), 16'(nib(bcd, i)));
      chk({tag, "_sel"}, 16'(sel0), 16'(en[0] ? sel_of(i) : 4'b1111));
    end
  endtask

  task automatic load(input logic [13:0] v);
    chk("ld_ready", 16'(ready0), 16'd1);
    score_in    = v;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    chk("ld_busy", 16'(busy0), 16'd1);
    repeat (15) tick();
    chk("ld_done", 16'(ready0), 16'd1);
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_rdy"}, 16'(ready0), 16'd1);
    chk({tag, "_busy"}, 16'(busy0), 16'd0);
    chk({tag, "_sel"}, 16'(sel0), 16'hE);
    chk({tag, "_num"}, 16'(num0), 16'd0);
    chk({tag, "_sel1"}, 16'(sel1), 16'hE);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    mcnt        = 0;
    rst_n       = 1'b0;
    score_in    = 14'd0;
    score_valid = 1'b0;
    blank_lz    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = 0;

    // asynchronous reset mid-cycle, then scan stepping
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_now("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = 0;
    scan("rst_scan", 16'h0000, 4'b1111, 20);

    // conversion latency for 1234
    score_in    = 14'd1234;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    chk("lat_e0_rdy", 16'(ready0), 16'd0);
    chk("lat_e0_busy", 16'(busy0), 16'd1);
    for (int e = 1; e <= 14; e++) begin
      tick();
      chk("lat_rdy", 16'(ready0), 16'd0);
      chk("lat_busy", 16'(busy0), 16'd1);
      chk("lat_hold", 16'(num0), 16'd0);
    end
    tick();
    chk("lat_e15_rdy", 16'(ready0), 16'd1);
    chk("lat_e15_busy", 16'(busy0), 16'd0);
    chk("lat_e15_num", 16'(num0), 16'(nib(16'h1234, (mcnt / 4) % 4)));
    scan("lat_scan", 16'h1234, 4'b1111, 16);

    // saturation plus back-pressure: 42 held while busy
    score_in    = 14'd10000;
    score_valid = 1'b1;
    tick();
    score_in = 14'd42;
    repeat (14) tick();
    chk("bp_e14_rdy", 16'(ready0), 16'd0);
    tick();
    chk("bp_e15_rdy", 16'(ready0), 16'd1);
    chk("sat_num", 16'(num0), 16'd9);
    tick();
    score_valid = 1'b0;
    chk("bp_acc_rdy", 16'(ready0), 16'd0);
    chk("bp_acc_num", 16'(num0), 16'd9);
    repeat (15) tick();
    chk("bp_42_rdy", 16'(ready0), 16'd1);
    scan("bp_scan", 16'h0042, 4'b1111, 16);

    // leading-zero blanking, including a live blank_lz change
    blank_lz = 1'b1;
    load(14'd7);
    scan("blk7", 16'h0007, 4'b0001, 16);
    blank_lz = 1'b0;
    scan("blk7_off", 16'h0007, 4'b1111, 16);
    blank_lz = 1'b1;
    load(14'd0);
    scan("blk0", 16'h0000, 4'b0001, 16);
    load(14'd1005);
    scan("blk1005", 16'h1005, 4'b1111, 16);
    load(14'd42);
    scan("blk42", 16'h0042, 4'b0011, 16);
    load(14'd16383);
    scan("blk_sat", 16'h9999, 4'b1111, 16);
    blank_lz = 1'b0;

    // reset during a conversion aborts it
    load(14'd8888);
    scan("r8888", 16'h8888, 4'b1111, 16);
    score_in    = 14'd5555;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_now("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = 0;
    scan("rst_mid_scan", 16'h0000, 4'b1111, 24);

    // per-cycle scan with a load of 0321 landing mid-stream
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("d1_pre_sel", 16'(sel1), 16'(sel_of(mcnt % 4)));
    end
    score_in    = 14'd321;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    chk("d1_e0_sel", 16'(sel1), 16'(sel_of(mcnt % 4)));
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("d1_cv_sel", 16'(sel1), 16'(sel_of(mcnt % 4)));
    end
    chk("d1_rdy", 16'(ready1), 16'd1);
    for (int k = 0; k < 8; k++) begin
      chk("d1_num", 16'(num1), 16'(nib(16'h0321, mcnt % 4)));
      tick();
      chk("d1_sel", 16'(sel1), 16'(sel_of(mcnt % 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
